pc_sequencer: RTL and testbench

- Controller that drives the pipelined core's program counter register.
- Each cycle it produces the next-PC value and the pcwrite enable.
- It also generates IF/ID write-enable, IF/ID flush and ID/EX bubble controls for load-use stalls, taken-branch redirects and external stalls.
- At end of program it drains the pipeline and halts the PC.

---
 rtl/pc_sequencer_pkg.sv | 17 +
 rtl/pc_sequencer_if.sv | 34 +++
 rtl/pc_sequencer_hazard_detect.sv | 14 +
 rtl/pc_sequencer.sv | 142 ++++++++++++++
 tb/tb_pc_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer slice: FSM state encoding,
// NOP/bubble constants and the register-index width.
package pc_seq_pkg;

  // Register file index width (x0..x31).
  localparam int REG_IDX_W = 5;

  // FSM state encoding, kept as plain constants for legacy tools.
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  // Canonical NOP (addi x0, x0, 0) that a bubble or flush turns into.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic        BUBBLE_ON = 1'b1;

endpackage

// File: rtl/pc_sequencer_if.sv
// Front-end control bus between the pipelined core (master) and the
// PC sequencer (slave).
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int PC_WIDTH = 7
);
  logic [PC_WIDTH-1:0]  pc_cur;
  logic                 idex_memread;
  logic [REG_IDX_W-1:0] idex_rd;
  logic [REG_IDX_W-1:0] ifid_rs1;
  logic [REG_IDX_W-1:0] ifid_rs2;
  logic                 branch_taken;
  logic [PC_WIDTH-1:0]  branch_target;
  logic                 ext_stall;
  logic [PC_WIDTH-1:0]  pc_next;
  logic                 pcwrite;
  logic                 ifid_write;
  logic                 ifid_flush;
  logic                 idex_bubble;
  logic                 halted;

  modport master (
    output pc_cur, idex_memread, idex_rd, ifid_rs1, ifid_rs2,
           branch_taken, branch_target, ext_stall,
    input  pc_next, pcwrite, ifid_write, ifid_flush, idex_bubble, halted
  );

  modport slave (
    input  pc_cur, idex_memread, idex_rd, ifid_rs1, ifid_rs2,
           branch_taken, branch_target, ext_stall,
    output pc_next, pcwrite, ifid_write, ifid_flush, idex_bubble, halted
  );
endinterface

// File: rtl/pc_sequencer_hazard_detect.sv
// Load-use hazard compare: the load in ID/EX writes a register that the
// instruction in IF/ID reads. Writes to x0 never create a hazard.
module hazard_detect
  import pc_seq_pkg::*;
(
  input  logic                 idex_memread_i,
  input  logic [REG_IDX_W-1:0] idex_rd_i,
  input  logic [REG_IDX_W-1:0] ifid_rs1_i,
  input  logic [REG_IDX_W-1:0] ifid_rs2_i,
  output logic                 lu_o
);
  assign lu_o = idex_memread_i && (idex_rd_i != '0) &&
                ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: next-PC selection, front-end stall/flush/bubble control,
// end-of-program drain and halt.
// Optional feature: define PC_SEQUENCER_PERF_EN to add the saturating
// stall_cycles / flush_count performance counters.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_WIDTH     = 7,
  parameter int PC_STEP      = 4,
  parameter int PC_LAST      = 124,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
`ifdef PC_SEQUENCER_PERF_EN
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count,
`endif
  pc_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                lu;
  logic                redirect;
  logic [PC_WIDTH-1:0] pc_next;
  logic                pcwrite, ifid_write, ifid_flush, idex_bubble, halted;

  hazard_detect u_hazard (
    .idex_memread_i (bus.idex_memread),
    .idex_rd_i      (bus.idex_rd),
    .ifid_rs1_i     (bus.ifid_rs1),
    .ifid_rs2_i     (bus.ifid_rs2),
    .lu_o           (lu)
  );

  // Output muxing and next-state selection by state and event priority.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    pc_next     = bus.pc_cur;
    pcwrite     = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    halted      = 1'b0;
    redirect    = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;

    if (reset) begin
      pc_next     = '0;
      ifid_flush  = 1'b1;
      idex_bubble = BUBBLE_ON;
    end else if (state_q == ST_HALT) begin
      ifid_flush  = 1'b1;
      idex_bubble = BUBBLE_ON;
      halted      = 1'b1;
    end else if ((state_q == ST_RUN || state_q == ST_DRAIN) && bus.branch_taken) begin
      // A resolved branch beats stalls and hazards, and revives a draining core.
      redirect    = 1'b1;
      pc_next     = bus.branch_target;
      pcwrite     = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = BUBBLE_ON;
      state_d     = ST_RUN;
      cnt_d       = '0;
    end else if (state_q == ST_DRAIN) begin
      ifid_write = 1'b1;
      ifid_flush = 1'b1;
      if (!bus.ext_stall) begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          state_d = ST_HALT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else if (state_q == ST_RUN) begin
      if (bus.ext_stall) begin
        // Whole front end holds; nothing new enters ID/EX, so no bubble.
      end else if (lu) begin
        idex_bubble = BUBBLE_ON;
      end else if (bus.pc_cur == PC_WIDTH'(PC_LAST)) begin
        // Last instruction fetched: let it pass, freeze the PC, start draining.
        ifid_write = 1'b1;
        state_d    = ST_DRAIN;
        cnt_d      = '0;
      end else begin
        pc_next    = bus.pc_cur + PC_WIDTH'(PC_STEP);
        pcwrite    = 1'b1;
        ifid_write = 1'b1;
      end
    end else begin
      // Unused encoding: fall back to RUN.
      state_d = ST_RUN;
      cnt_d   = '0;
    end
  end

  assign bus.pc_next     = pc_next;
  assign bus.pcwrite     = pcwrite;
  assign bus.ifid_write  = ifid_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.halted      = halted;

  // FSM state and drain counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PC_SEQUENCER_PERF_EN
  logic [15:0] stall_q, flush_q;

  // Saturating counters: PC-hold cycles while running, and branch redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (state_q == ST_RUN && !pcwrite && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
      if (redirect && flush_q != 16'hFFFF)
        flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a behavioural model of the front-end
// rules plus a PC register emulated from the model's own decisions, checked
// every cycle, with directed scenarios and a randomized phase.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int PW    = 7;
  localparam int STEP  = 4;
  localparam int LAST  = 124;
  localparam int DRAIN = 4;

  // Model phases (bench's own notation).
  localparam int M_FETCH = 0;
  localparam int M_DRAIN = 1;
  localparam int M_DONE  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_WIDTH(PW)) bus ();

`ifdef PC_SEQUENCER_PERF_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  pc_sequencer #(
    .PC_WIDTH(PW), .PC_STEP(STEP), .PC_LAST(LAST), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef PC_SEQUENCER_PERF_EN
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
`endif
    .bus          (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state.
  int m_mode    = M_FETCH;
  int m_drained = 0;
  int pc_reg    = 0;
  int m_stall   = 0;
  int m_flush   = 0;

  // Expected outputs for the current cycle.
  int e_pc_next;
  bit e_pcw, e_ifw, e_flush, e_bubble, e_halted, e_redirect, e_enter;

  // Last observed DUT outputs, for hand-computed literal checks.
  logic [31:0] obs_pc_next;
  logic        obs_pcw, obs_ifw, obs_flush, obs_bubble, obs_halted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compute_expected();
    bit lu;
    lu = bus.idex_memread && (bus.idex_rd != 0) &&
         (bus.idex_rd == bus.ifid_rs1 || bus.idex_rd == bus.ifid_rs2);
    e_pc_next = int'(bus.pc_cur);
    {e_pcw, e_ifw, e_flush, e_bubble, e_halted, e_redirect, e_enter} = '0;
    if (reset) begin
      e_pc_next = 0; e_flush = 1; e_bubble = 1;
    end else if (m_mode == M_DONE) begin
      e_flush = 1; e_bubble = 1; e_halted = 1;
    end else if (bus.branch_taken) begin
      e_pc_next = int'(bus.branch_target);
      e_pcw = 1; e_ifw = 1; e_flush = 1; e_bubble = 1; e_redirect = 1;
    end else if (m_mode == M_DRAIN) begin
      e_ifw = 1; e_flush = 1;
    end else if (bus.ext_stall) begin
      // everything held
    end else if (lu) begin
      e_bubble = 1;
    end else if (int'(bus.pc_cur) == LAST) begin
      e_ifw = 1; e_enter = 1;
    end else begin
      e_pcw = 1; e_ifw = 1;
      e_pc_next = (int'(bus.pc_cur) + STEP) % (1 << PW);
    end
  endtask

  task automatic update_model();
    if (reset) begin
      m_mode = M_FETCH; m_drained = 0; pc_reg = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (e_pcw) pc_reg = e_pc_next;
      if (m_mode == M_FETCH && !e_pcw && m_stall < 65535) m_stall++;
      if (e_redirect && m_flush < 65535) m_flush++;
      if (m_mode != M_DONE) begin
        if (bus.branch_taken) begin
          m_mode = M_FETCH; m_drained = 0;
        end else if (m_mode == M_DRAIN) begin
          if (!bus.ext_stall) begin
            m_drained++;
            if (m_drained == DRAIN) m_mode = M_DONE;
          end
        end else if (e_enter) begin
          m_mode = M_DRAIN; m_drained = 0;
        end
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    compute_expected();
    check("pc_next",     32'(bus.pc_next),     32'(e_pc_next));
    check("pcwrite",     32'(bus.pcwrite),     32'(e_pcw));
    check("ifid_write",  32'(bus.ifid_write),  32'(e_ifw));
    check("ifid_flush",  32'(bus.ifid_flush),  32'(e_flush));
    check("idex_bubble", 32'(bus.idex_bubble), 32'(e_bubble));
    check("halted",      32'(bus.halted),      32'(e_halted));
`ifdef PC_SEQUENCER_PERF_EN
    check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    check("flush_count",  32'(flush_count),  32'(m_flush));
`endif
    obs_pc_next = 32'(bus.pc_next);
    obs_pcw     = bus.pcwrite;
    obs_ifw     = bus.ifid_write;
    obs_flush   = bus.ifid_flush;
    obs_bubble  = bus.idex_bubble;
    obs_halted  = bus.halted;
    @(posedge clk);
    update_model();
    #1;
    bus.pc_cur = PW'(pc_reg);
  endtask

  task automatic idle_inputs();
    bus.idex_memread  = 1'b0;
    bus.idex_rd       = '0;
    bus.ifid_rs1      = '0;
    bus.ifid_rs2      = '0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.ext_stall     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Free-run until the PC register holds the last address (bounded).
  task automatic run_to_last();
    for (int i = 0; i < 200 && pc_reg != LAST; i++) step();
    check("reach_last_bound", 32'(pc_reg), 32'(LAST));
  endtask

  // Count drain cycles until halted is seen (bounded), stalling the first n.
  task automatic drain_count(input int stall_n, output int n);
    n = 0;
    while (n < 20) begin
      bus.ext_stall = (n < stall_n);
      step();
      if (obs_halted) break;
      n++;
    end
    bus.ext_stall = 1'b0;
  endtask

  initial begin
    int n;
    int halt_wait;
    idle_inputs();
    bus.pc_cur = '0;
    reset = 1'b1;
    step();
    check("reset_pcwrite", 32'(obs_pcw), 0);
    check("reset_flush",   32'(obs_flush), 1);
    do_reset();

    // Free run from 0.
    for (int i = 0; i < 4; i++) begin
      step();
      check("free_run_pc", obs_pc_next, 32'(STEP * (i + 1)));
      check("free_run_we", 32'(obs_pcw), 1);
    end

    // Load-use at pc 16: one bubble, then advance to 20.
    bus.idex_memread = 1'b1; bus.idex_rd = 5'd5; bus.ifid_rs2 = 5'd5;
    step();
    check("lu_pcwrite", 32'(obs_pcw), 0);
    check("lu_ifid_we", 32'(obs_ifw), 0);
    check("lu_bubble",  32'(obs_bubble), 1);
    idle_inputs();
    step();
    check("lu_resume_pc", obs_pc_next, 20);
    check("lu_resume_bubble", 32'(obs_bubble), 0);

    // Same pattern targeting x0: no stall.
    bus.idex_memread = 1'b1; bus.idex_rd = 5'd0; bus.ifid_rs2 = 5'd0;
    step();
    check("x0_no_stall", 32'(obs_pcw), 1);
    check("x0_pc", obs_pc_next, 24);
    idle_inputs();

    // Branch beats ext_stall and a load-use hazard.
    bus.branch_taken = 1'b1; bus.branch_target = 7'd40; bus.ext_stall = 1'b1;
    bus.idex_memread = 1'b1; bus.idex_rd = 5'd3; bus.ifid_rs1 = 5'd3;
    step();
    check("br_pc",     obs_pc_next, 40);
    check("br_pcw",    32'(obs_pcw), 1);
    check("br_flush",  32'(obs_flush), 1);
    check("br_bubble", 32'(obs_bubble), 1);
    idle_inputs();

    // End of program: drain then halt.
    run_to_last();
    step();
    check("last_pcwrite", 32'(obs_pcw), 0);
    check("last_ifid_we", 32'(obs_ifw), 1);
    drain_count(0, n);
    check("drain_cycles", 32'(n), 4);
    bus.branch_taken = 1'b1; bus.branch_target = 7'd8;
    step();
    check("halt_ignores_branch", 32'(obs_pcw), 0);
    idle_inputs();

    // Two stalled drain cycles delay halt by two.
    do_reset();
    run_to_last();
    step();
    drain_count(2, n);
    check("drain_cycles_stalled", 32'(n), 6);

    // Late branch on drain cycle 2 resumes fetching.
    do_reset();
    run_to_last();
    step();
    step();
    bus.branch_taken = 1'b1; bus.branch_target = 7'd8;
    step();
    check("late_br_pc",  obs_pc_next, 8);
    check("late_br_pcw", 32'(obs_pcw), 1);
    idle_inputs();
    step();
    check("resume_pc",     obs_pc_next, 12);
    check("resume_halted", 32'(obs_halted), 0);

`ifdef PC_SEQUENCER_PERF_EN
    // 3 load-use stalls + 2 ext-stall cycles + 1 branch.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.idex_memread = 1'b1; bus.idex_rd = 5'd7; bus.ifid_rs1 = 5'd7;
      step();
      idle_inputs();
      step();
    end
    bus.ext_stall = 1'b1;
    step();
    step();
    idle_inputs();
    bus.branch_taken = 1'b1; bus.branch_target = 7'd0;
    step();
    idle_inputs();
    step();
    check("perf_stall_lit", 32'(stall_cycles), 5);
    check("perf_flush_lit", 32'(flush_count), 1);
    run_to_last();
    step();
    step();
    do_reset();
    step();
    check("perf_reset_stall", 32'(stall_cycles), 0);
    check("perf_reset_flush", 32'(flush_count), 0);
`endif

    // Randomized phase.
    do_reset();
    halt_wait = 0;
    for (int i = 0; i < 3000; i++) begin
      idle_inputs();
      bus.ext_stall    = ($urandom_range(0, 5) == 0);
      bus.idex_memread = ($urandom_range(0, 2) == 0);
      bus.idex_rd      = 5'($urandom_range(0, 7));
      bus.ifid_rs1     = 5'($urandom_range(0, 7));
      bus.ifid_rs2     = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) begin
        bus.branch_taken  = 1'b1;
        bus.branch_target = PW'($urandom_range(0, 31) * 4);
      end
      if (m_mode == M_DONE) halt_wait++;
      reset = (halt_wait > 5) || ($urandom_range(0, 299) == 0);
      if (reset) halt_wait = 0;
      step();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
